// File: rtl/updown_counter_ranged.sv
// updown_counter_ranged
// Up/down counter confined to a programmable range [min_value, max_value].
// The step size is selectable (0 counts as 1). Three boundary modes are
// supported: wrap, saturate and one-shot. The counter also provides
// terminal-count pulses, sticky overflow/underflow flags and a
// configuration-error indication.
module updown_counter_ranged #(
  parameter int               WIDTH       = 8,
  parameter int               STEP_W      = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              load,
  input  logic              up_down_n,
  input  logic [WIDTH-1:0]  data_input,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  min_value,
  input  logic [WIDTH-1:0]  max_value,
  input  logic              clear_flags,
  output logic [WIDTH-1:0]  data_output,
  output logic              tc_up,
  output logic              tc_down,
  output logic              overflow,
  output logic              underflow,
  output logic              done,
  output logic              cfg_err
);

  localparam int         CW           = WIDTH + 1;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    RUN,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] cnt_next;
  logic             tc_up_next, tc_down_next;
  logic             overflow_next, underflow_next;

  logic [CW-1:0]    step_eff;
  logic [CW-1:0]    cnt_ext, min_ext, max_ext;
  logic [CW-1:0]    sum_up, diff_down;
  logic             borrow;
  logic             below_min, at_min;
  logic             wrap_mode;
  logic [WIDTH-1:0] load_clamped;

  assign cfg_err   = (min_value > max_value);
  assign done      = (state == DONE);

  // Reserved mode 11 behaves like wrap, so "wrap" means "neither saturate nor one-shot".
  assign wrap_mode = (mode != MODE_SAT) && (mode != MODE_ONESHOT);

  assign step_eff  = (step == '0) ? CW'(1) : CW'(step);
  assign cnt_ext   = {1'b0, data_output};
  assign min_ext   = {1'b0, min_value};
  assign max_ext   = {1'b0, max_value};
  assign sum_up    = cnt_ext + step_eff;
  assign diff_down = cnt_ext - step_eff;

  // A borrow below zero is treated the same as landing below min_value.
  assign borrow    = (cnt_ext < step_eff);
  assign below_min = borrow || (diff_down < min_ext);
  assign at_min    = !borrow && (diff_down == min_ext);

  assign load_clamped = (data_input < min_value) ? min_value :
                        (data_input > max_value) ? max_value : data_input;

  // Next-state logic. Priority each cycle: cfg_err hold, then load,
  // then the frozen one-shot state, then enable.
  always_comb begin
    cnt_next       = data_output;
    state_next     = state;
    tc_up_next     = 1'b0;
    tc_down_next   = 1'b0;
    overflow_next  = overflow  & ~clear_flags;
    underflow_next = underflow & ~clear_flags;

    if (!cfg_err) begin
      if (load) begin
        cnt_next   = load_clamped;
        state_next = RUN;
      end else if (state == DONE) begin
        if (mode != MODE_ONESHOT) begin
          state_next = RUN;
        end
      end else if (enable) begin
        if (up_down_n) begin
          if (sum_up < max_ext) begin
            cnt_next = sum_up[WIDTH-1:0];
          end else begin
            tc_up_next = 1'b1;
            cnt_next   = max_value;
            if (sum_up != max_ext) begin
              overflow_next = 1'b1;
              if (wrap_mode) begin
                cnt_next = min_value;
              end
            end
            if (mode == MODE_ONESHOT) begin
              state_next = DONE;
            end
          end
        end else begin
          if (!below_min && !at_min) begin
            cnt_next = diff_down[WIDTH-1:0];
          end else begin
            tc_down_next = 1'b1;
            cnt_next     = min_value;
            if (below_min) begin
              underflow_next = 1'b1;
              if (wrap_mode) begin
                cnt_next = max_value;
              end
            end
            if (mode == MODE_ONESHOT) begin
              state_next = DONE;
            end
          end
        end
      end
    end
  end

  // One-shot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Count, terminal-count pulses and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_output <= RESET_VALUE;
      tc_up       <= 1'b0;
      tc_down     <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      data_output <= cnt_next;
      tc_up       <= tc_up_next;
      tc_down     <= tc_down_next;
      overflow    <= overflow_next;
      underflow   <= underflow_next;
    end
  end

endmodule

// File: tb/tb_updown_counter_ranged.sv
// tb_updown_counter_ranged
// Directed bench for updown_counter_ranged. An integer-arithmetic reference
// model tracks the expected outputs and is compared against the DUT on every
// falling clock edge. Literal expectations along the directed sequences
// independently pin the model's behaviour.
module tb_updown_counter_ranged;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              load;
  logic              up_down_n;
  logic [WIDTH-1:0]  data_input;
  logic [STEP_W-1:0] step;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  min_value;
  logic [WIDTH-1:0]  max_value;
  logic              clear_flags;
  logic [WIDTH-1:0]  data_output;
  logic              tc_up;
  logic              tc_down;
  logic              overflow;
  logic              underflow;
  logic              done;
  logic              cfg_err;

  int total = 0;
  int bad   = 0;

  int m_cnt  = 0;
  int m_tcu  = 0;
  int m_tcd  = 0;
  int m_ovf  = 0;
  int m_udf  = 0;
  int m_done = 0;

  updown_counter_ranged #(
    .WIDTH(WIDTH),
    .STEP_W(STEP_W),
    .RESET_VALUE(8'd0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .load(load),
    .up_down_n(up_down_n),
    .data_input(data_input),
    .step(step),
    .mode(mode),
    .min_value(min_value),
    .max_value(max_value),
    .clear_flags(clear_flags),
    .data_output(data_output),
    .tc_up(tc_up),
    .tc_down(tc_down),
    .overflow(overflow),
    .underflow(underflow),
    .done(done),
    .cfg_err(cfg_err)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the rising edge consume them, return just after it.
  task automatic applyStimulus(input logic en, input logic ld, input logic ud,
                               input int din, input int stp, input int md,
                               input int mn, input int mx, input logic clr);
    enable      = en;
    load        = ld;
    up_down_n   = ud;
    data_input  = WIDTH'(din);
    step        = STEP_W'(stp);
    mode        = 2'(md);
    min_value   = WIDTH'(mn);
    max_value   = WIDTH'(mx);
    clear_flags = clr;
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain signed integer arithmetic on the sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    int s, n, lo, hi;
    if (!rst_n) begin
      m_cnt = 0; m_tcu = 0; m_tcd = 0; m_ovf = 0; m_udf = 0; m_done = 0;
    end else begin
      lo = int'(min_value);
      hi = int'(max_value);
      s  = (step == 0) ? 1 : int'(step);
      m_tcu = 0;
      m_tcd = 0;
      if (clear_flags) begin
        m_ovf = 0;
        m_udf = 0;
      end
      if (lo > hi) begin
        // configuration error: everything holds
      end else if (load) begin
        if (int'(data_input) < lo)      m_cnt = lo;
        else if (int'(data_input) > hi) m_cnt = hi;
        else                            m_cnt = int'(data_input);
        m_done = 0;
      end else if (m_done != 0) begin
        if (mode != 2'b10) m_done = 0;
      end else if (enable) begin
        if (up_down_n) begin
          n = m_cnt + s;
          if (n < hi) m_cnt = n;
          else begin
            m_tcu = 1;
            if (n == hi) m_cnt = hi;
            else begin
              m_ovf = 1;
              m_cnt = (mode == 2'b01 || mode == 2'b10) ? hi : lo;
            end
            if (mode == 2'b10) m_done = 1;
          end
        end else begin
          n = m_cnt - s;
          if (n > lo) m_cnt = n;
          else begin
            m_tcd = 1;
            if (n == lo) m_cnt = lo;
            else begin
              m_udf = 1;
              m_cnt = (mode == 2'b01 || mode == 2'b10) ? lo : hi;
            end
            if (mode == 2'b10) m_done = 1;
          end
        end
      end
    end
  end

  // Every falling edge: DUT outputs against the reference model.
  always @(negedge clk) begin
    checkOutput("model_data_output", int'(data_output), m_cnt);
    checkOutput("model_tc_up",       int'(tc_up),       m_tcu);
    checkOutput("model_tc_down",     int'(tc_down),     m_tcd);
    checkOutput("model_overflow",    int'(overflow),    m_ovf);
    checkOutput("model_underflow",   int'(underflow),   m_udf);
    checkOutput("model_done",        int'(done),        m_done);
    checkOutput("model_cfg_err",     int'(cfg_err),     (min_value > max_value) ? 1 : 0);
  end

  // Directed sequences with hand-computed expectations.
  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    load        = 1'b0;
    up_down_n   = 1'b1;
    data_input  = '0;
    step        = 4'd1;
    mode        = 2'b00;
    min_value   = 8'd3;
    max_value   = 8'd10;
    clear_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_data",      int'(data_output), 0);
    checkOutput("reset_tc_up",     int'(tc_up),       0);
    checkOutput("reset_overflow",  int'(overflow),    0);
    checkOutput("reset_done",      int'(done),        0);
    rst_n = 1'b1;

    // wrap mode, range 3..10, step 1, up from 8
    applyStimulus(0, 1, 1, 8, 1, 0, 3, 10, 0);
    checkOutput("wrap_load8", int'(data_output), 8);
    applyStimulus(1, 0, 1, 0, 1, 0, 3, 10, 0);
    checkOutput("wrap_9", int'(data_output), 9);
    checkOutput("wrap_9_tc", int'(tc_up), 0);
    applyStimulus(1, 0, 1, 0, 1, 0, 3, 10, 0);
    checkOutput("wrap_10", int'(data_output), 10);
    checkOutput("wrap_10_tc", int'(tc_up), 1);
    checkOutput("wrap_10_ovf", int'(overflow), 0);
    applyStimulus(1, 0, 1, 0, 1, 0, 3, 10, 0);
    checkOutput("wrap_3", int'(data_output), 3);
    checkOutput("wrap_3_tc", int'(tc_up), 1);
    checkOutput("wrap_3_ovf", int'(overflow), 1);
    applyStimulus(1, 0, 1, 0, 1, 0, 3, 10, 0);
    checkOutput("wrap_4", int'(data_output), 4);
    checkOutput("wrap_4_tc", int'(tc_up), 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 3, 10, 1);
    checkOutput("wrap_clear_ovf", int'(overflow), 0);

    // saturate mode, step 4, down from 9
    applyStimulus(0, 1, 0, 9, 4, 1, 3, 10, 0);
    applyStimulus(1, 0, 0, 0, 4, 1, 3, 10, 0);
    checkOutput("sat_5", int'(data_output), 5);
    checkOutput("sat_5_tcd", int'(tc_down), 0);
    applyStimulus(1, 0, 0, 0, 4, 1, 3, 10, 0);
    checkOutput("sat_3", int'(data_output), 3);
    checkOutput("sat_3_tcd", int'(tc_down), 1);
    checkOutput("sat_3_udf", int'(underflow), 1);
    applyStimulus(1, 0, 0, 0, 4, 1, 3, 10, 0);
    checkOutput("sat_hold", int'(data_output), 3);
    checkOutput("sat_hold_tcd", int'(tc_down), 1);
    applyStimulus(0, 0, 0, 0, 4, 1, 3, 10, 1);
    checkOutput("sat_clear_udf", int'(underflow), 0);
    checkOutput("sat_clear_tcd", int'(tc_down), 0);

    // one-shot mode, step 2, up from 7
    applyStimulus(0, 1, 1, 7, 2, 2, 3, 10, 0);
    applyStimulus(1, 0, 1, 0, 2, 2, 3, 10, 0);
    checkOutput("os_9", int'(data_output), 9);
    applyStimulus(1, 0, 1, 0, 2, 2, 3, 10, 0);
    checkOutput("os_10", int'(data_output), 10);
    checkOutput("os_10_done", int'(done), 1);
    checkOutput("os_10_tc", int'(tc_up), 1);
    applyStimulus(1, 0, 1, 0, 2, 2, 3, 10, 0);
    checkOutput("os_frozen", int'(data_output), 10);
    checkOutput("os_frozen_tc", int'(tc_up), 0);
    checkOutput("os_frozen_done", int'(done), 1);
    applyStimulus(0, 1, 1, 5, 2, 2, 3, 10, 0);
    checkOutput("os_load5", int'(data_output), 5);
    checkOutput("os_load5_done", int'(done), 0);
    // reach DONE again, then leave one-shot mode while frozen
    repeat (3) applyStimulus(1, 0, 1, 0, 2, 2, 3, 10, 0);
    checkOutput("os_again_done", int'(done), 1);
    applyStimulus(1, 0, 1, 0, 2, 0, 3, 10, 0);
    checkOutput("os_leave_done", int'(done), 0);
    checkOutput("os_leave_cnt", int'(data_output), 10);
    applyStimulus(1, 0, 1, 0, 2, 0, 3, 10, 0);
    checkOutput("os_leave_wrap", int'(data_output), 3);
    applyStimulus(0, 0, 1, 0, 1, 0, 3, 10, 1);

    // load clamping and load priority over enable
    applyStimulus(0, 1, 1, 200, 1, 0, 3, 10, 0);
    checkOutput("clamp_hi", int'(data_output), 10);
    applyStimulus(0, 1, 1, 0, 1, 0, 3, 10, 0);
    checkOutput("clamp_lo", int'(data_output), 3);
    applyStimulus(1, 1, 1, 6, 1, 0, 3, 10, 0);
    checkOutput("load_wins", int'(data_output), 6);
    checkOutput("load_no_tc", int'(tc_up), 0);

    // range shrinks below the current count: next up step overflows and wraps
    applyStimulus(1, 0, 1, 0, 1, 0, 3, 5, 0);
    checkOutput("range_wrap", int'(data_output), 3);
    checkOutput("range_ovf", int'(overflow), 1);

    // asynchronous reset in the middle of counting
    applyStimulus(0, 1, 1, 6, 1, 0, 3, 10, 0);
    applyStimulus(1, 0, 1, 0, 1, 0, 3, 10, 0);
    checkOutput("pre_reset_7", int'(data_output), 7);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_cnt", int'(data_output), 0);
    checkOutput("async_reset_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    applyStimulus(1, 0, 1, 0, 1, 0, 3, 10, 0);
    checkOutput("post_reset_1", int'(data_output), 1);
    applyStimulus(1, 0, 1, 0, 1, 0, 3, 10, 0);
    checkOutput("post_reset_2", int'(data_output), 2);

    // configuration error: counter holds, load ignored
    applyStimulus(0, 1, 1, 4, 1, 0, 3, 10, 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 12, 5, 0);
    checkOutput("cfg_err_set", int'(cfg_err), 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 9, 1, 0, 12, 5, 0);
      checkOutput("cfg_hold_cnt", int'(data_output), 4);
      checkOutput("cfg_hold_tc", int'(tc_up), 0);
    end
    applyStimulus(1, 0, 1, 0, 1, 0, 3, 5, 0);
    checkOutput("cfg_err_clear", int'(cfg_err), 0);
    checkOutput("cfg_resume", int'(data_output), 5);
    checkOutput("cfg_resume_tc", int'(tc_up), 1);

    // mixed sweep across modes, directions and steps, checked by the model
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, (i % 9) == 0, ((i / 3) % 2) == 0, (i * 37) % 256,
                    i % 6, i % 4, 2 + (i % 3), 20 + (i % 5), (i % 11) == 0);
    end

    applyStimulus(0, 0, 1, 0, 1, 0, 3, 10, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
